// File: rtl/dmem_port_sequencer.sv
// Arbitrates the CPU and debug ports onto the byte-wide data memory and
// breaks each word/half/byte access into consecutive one-byte memory cycles.
module dmem_port_sequencer #(
    parameter int MEM_AW = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [1:0]        cpu_size,
    input  logic              cpu_sext,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_ack,
    output logic              cpu_err,
    output logic [31:0]       cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [1:0]        dbg_size,
    input  logic              dbg_sext,
    input  logic [31:0]       dbg_addr,
    input  logic [31:0]       dbg_wdata,
    output logic              dbg_ack,
    output logic              dbg_err,
    output logic [31:0]       dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {IDLE, XFER, DRAIN, DONE} state_t;

    state_t            state, state_next;
    logic              gnt_dbg, last_dbg;
    logic              lat_we, lat_sext, lat_err;
    logic [1:0]        lat_size, idx, idx_prev, nlast;
    logic [MEM_AW-1:0] base;
    logic [31:0]       lat_wdata, result, assembled, load_value;

    logic              any_req, pick_dbg, sel_we, sel_sext, sel_err;
    logic [1:0]        sel_size;
    logic [MEM_AW-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic              unused_addr_bits;

    // Upper request address bits are dropped: the memory only decodes MEM_AW bits.
    assign unused_addr_bits = ^{cpu_addr[31:MEM_AW], dbg_addr[31:MEM_AW]};

    // Round-robin: on a tie the requester that was not granted last wins.
    assign any_req   = cpu_req | dbg_req;
    assign pick_dbg  = dbg_req & (~cpu_req | ~last_dbg);
    assign sel_we    = pick_dbg ? dbg_we    : cpu_we;
    assign sel_size  = pick_dbg ? dbg_size  : cpu_size;
    assign sel_sext  = pick_dbg ? dbg_sext  : cpu_sext;
    assign sel_addr  = pick_dbg ? dbg_addr[MEM_AW-1:0] : cpu_addr[MEM_AW-1:0];
    assign sel_wdata = pick_dbg ? dbg_wdata : cpu_wdata;
    assign idx_prev  = idx - 2'd1;

    always_comb begin
        sel_err = 1'b0;
        case (sel_size)
            2'b01:   sel_err = sel_addr[0];
            2'b10:   sel_err = |sel_addr[1:0];
            2'b11:   sel_err = 1'b1;
            default: sel_err = 1'b0;
        endcase
    end

    always_comb begin
        nlast = 2'd3;
        case (lat_size)
            2'b00:   nlast = 2'd0;
            2'b01:   nlast = 2'd1;
            default: nlast = 2'd3;
        endcase
    end

    // The last read byte arrives during DRAIN and is merged here before extension.
    always_comb begin
        assembled = result;
        assembled[{nlast, 3'b000} +: 8] = mem_rdata;
        load_value = assembled;
        case (lat_size)
            2'b00:   load_value = {(lat_sext ? {24{assembled[7]}}  : 24'h0), assembled[7:0]};
            2'b01:   load_value = {(lat_sext ? {16{assembled[15]}} : 16'h0), assembled[15:0]};
            default: load_value = assembled;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (any_req) state_next = sel_err ? DONE : XFER;
            XFER:  if (idx == nlast) state_next = lat_we ? DONE : DRAIN;
            DRAIN: state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt_dbg   <= 1'b0;
            last_dbg  <= 1'b1;
            lat_we    <= 1'b0;
            lat_sext  <= 1'b0;
            lat_err   <= 1'b0;
            lat_size  <= 2'b00;
            idx       <= 2'd0;
            base      <= '0;
            lat_wdata <= 32'h0;
            result    <= 32'h0;
            cpu_rdata <= 32'h0;
            dbg_rdata <= 32'h0;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    gnt_dbg   <= pick_dbg;
                    last_dbg  <= pick_dbg;
                    lat_we    <= sel_we;
                    lat_sext  <= sel_sext;
                    lat_err   <= sel_err;
                    lat_size  <= sel_size;
                    base      <= sel_addr;
                    lat_wdata <= sel_wdata;
                    idx       <= 2'd0;
                    result    <= 32'h0;
                end
                XFER: begin
                    idx <= idx + 2'd1;
                    if (!lat_we && idx != 2'd0)
                        result[{idx_prev, 3'b000} +: 8] <= mem_rdata;
                end
                DRAIN: begin
                    if (gnt_dbg) dbg_rdata <= load_value;
                    else         cpu_rdata <= load_value;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 8'h0;
        cpu_ack   = 1'b0;
        cpu_err   = 1'b0;
        dbg_ack   = 1'b0;
        dbg_err   = 1'b0;
        if (state == XFER) begin
            mem_en    = 1'b1;
            mem_we    = lat_we;
            mem_addr  = base + MEM_AW'(idx);
            mem_wdata = lat_wdata[{idx, 3'b000} +: 8];
        end
        if (state == DONE) begin
            cpu_ack = ~gnt_dbg;
            cpu_err = ~gnt_dbg & lat_err;
            dbg_ack = gnt_dbg;
            dbg_err = gnt_dbg & lat_err;
        end
    end

endmodule

// File: doc/dmem_port_sequencer.md
# dmem_port_sequencer

Shares the single-ported, byte-wide data memory between the CPU load/store path and the debug/loader port, and sequences each word, halfword or byte access into consecutive one-byte memory cycles. Little-endian byte order is used: the lowest address holds the LSB. Loads are zero- or sign-extended to 32 bits. The block sits between the requesters and `dmemory`.

## Interface
- `MEM_AW`, default 10: data memory byte-address width; request addresses are truncated to `addr[MEM_AW-1:0]`.
- `clk`  in  1  system clock, all state on the rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `cpu_req`, `dbg_req`  in  1  access request; held high with stable fields until the matching ack.
- `cpu_we`, `dbg_we`  in  1  1 = store, 0 = load.
- `cpu_size`, `dbg_size`  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- `cpu_sext`, `dbg_sext`  in  1  sign-extend the load result (ignored for word).
- `cpu_addr`, `dbg_addr`  in  32  byte address.
- `cpu_wdata`, `dbg_wdata`  in  32  store data; the low bytes are used for byte and half.
- `cpu_ack`, `dbg_ack`  out  1  one-cycle completion pulse.
- `cpu_err`, `dbg_err`  out  1  valid with ack; misaligned or illegal size.
- `cpu_rdata`, `dbg_rdata`  out  32  load result, updated only at a load ack and held afterwards.
- `mem_en`  out  1  memory cycle strobe.
- `mem_we`  out  1  byte write enable.
- `mem_addr`  out  MEM_AW  byte address.
- `mem_wdata`  out  8  write byte.
- `mem_rdata`  in  8  read byte, synchronous: valid the cycle after `mem_en` with `mem_we` low.

## Operation
- States:
  - `IDLE`: arbitrate.
  - `XFER`: issue the bytes.
  - `DRAIN`: capture the last read byte.
  - `DONE`: ack.
- Arbitration in `IDLE`:
  - Only one request present: it is granted.
  - Both present: round-robin. The requester not granted last wins.
  - The last-granted pointer resets to "dbg", so the CPU wins the first tie.
- Byte count N: 1, 2 or 4 from size. The grant latches addr, we, size, sext and wdata.
- Error check at grant:
  - Condition: size = 11, half with `addr[0]` = 1, or word with `addr[1:0]` ≠ 0.
  - Action: go directly to `DONE` with err = 1. No `mem_en` is issued and rdata is unchanged.
- `XFER`, byte i = 0..N-1, one per cycle:
  - `mem_en` = 1, `mem_addr` = base + i, `mem_we` = we.
  - `mem_wdata` = wdata[8i+7:8i].
- Load capture: `mem_rdata` for byte i is stored into result[8i+7:8i] in the following cycle. The last byte is captured in `DRAIN`.
- Extension:
  - Byte: sext ? {24{b0[7]}} : 24'h0, then b0.
  - Half: sext ? {16{b1[7]}} : 16'h0, then b1,b0.
  - Word: no extension.
- Store: `XFER` goes to `DONE` with no `DRAIN`.
- `DONE`:
  - The granted requester's ack = 1 for exactly one cycle; err as computed; rdata updated on a load.
  - The next state is always `IDLE`. The requester drops req on the edge where it samples ack.
- Outputs for the non-granted requester stay 0 (ack, err); its rdata holds.
- Address arithmetic is modulo 2^MEM_AW: a word at the top address wraps byte by byte. Aligned accesses never wrap.

## Timing
- Let T = the `IDLE` cycle in which a request is granted.
- Store of N bytes: `mem_en` in T+1..T+N; ack at T+N+1. Word store = 5 cycles, request to ack.
- Load of N bytes: `mem_en` in T+1..T+N; `DRAIN` at T+N+1; ack at T+N+2. Word load = 6 cycles.
- Error: ack with err at T+1.
- Back-to-back: a new grant is possible in the `IDLE` cycle after `DONE`. Minimum spacing is 1 idle cycle.
- A request arriving while busy waits. Requests are never dropped or merged.
- `mem_en`, `mem_we`, `mem_addr` and `mem_wdata` are driven from registered state. All mem outputs are 0 outside `XFER`.
- Reset (asserted at any time, including mid-`XFER`):
  - Immediately go to `IDLE`.
  - All outputs go to 0: acks, errs, rdatas, `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`.
  - The pointer goes to "dbg".
  - The partial transaction is abandoned and never acked. Memory bytes already written stay written.

## Test plan
- CPU word store 32'h00000004 at addr 8:
  - Required: `mem_en` in 4 consecutive cycles at addrs 8,9,10,11 with bytes 04,00,00,00.
  - `cpu_ack` 5 cycles after grant; memory bytes[8..11] = 04,00,00,00.
- Memory bytes[16..19] = AA,FF,FF,FF, and bytes[24..25] = EF,BE:
  - Signed byte load at 16 → `cpu_rdata` = FFFFFFAA.
  - Unsigned byte load at 16 → 000000AA.
  - Signed half load at 24 → FFFFBEEF.
  - Word load at 8 → 00000004, with ack 6 cycles after grant.
- Misalignment:
  - Word at addr 10 → ack + err at T+1, no `mem_en`, rdata unchanged.
  - Half at addr 25 → ack + err at T+1, no `mem_en`, rdata unchanged.
  - size 11 → ack + err at T+1, no `mem_en`, rdata unchanged.
- Contention: cpu_req and dbg_req are raised in the same cycle and both re-request immediately after each ack.
  - Required grant order: cpu, dbg, cpu, dbg.
  - No ack is ever seen on the wrong port.
- Reset: assert `reset_n` = 0 during the 3rd byte of a word store to addr 16.
  - Required: all outputs 0 immediately, and no ack is issued.
  - Bytes 16 and 17 are written, bytes 18 and 19 are unchanged.
  - After release, a new CPU request completes normally.
